// File: rtl/wb_select_stage_if.sv
// wb_select_stage_if: MEM->WB handshake bundle (valid/ready, write-data sources, load controls, destination)
//   master : MEM stage side, drives the instruction and samples in_ready
//   slave  : write-back stage side, consumes the instruction and drives in_ready
interface wb_select_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_ADDR_W = 5,
  parameter int NSRC = 4,
  parameter int SEL_W = $clog2(NSRC)
);
  logic in_valid;
  logic in_ready;
  logic [SEL_W-1:0] wd_sel;
  logic [NSRC*DATA_W-1:0] src_data;
  logic [1:0] load_size;
  logic load_signed;
  logic [1:0] addr_lo;
  logic [REG_ADDR_W-1:0] rd_addr;
  logic reg_write;
  modport master(output in_valid, wd_sel, src_data, load_size, load_signed, addr_lo, rd_addr, reg_write, input in_ready);
  modport slave(input in_valid, wd_sel, src_data, load_size, load_signed, addr_lo, rd_addr, reg_write, output in_ready);
endinterface

// File: rtl/wb_select_stage.sv
// wb_select_stage: MEM/WB register with NSRC-way write-data select, load alignment/extension and forwarding tap
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   up         : MEM-side bundle (slave modport); in_ready = !stall
//   stall      : hold the stage contents; flush : empty the stage (wins over stall)
//   rf_*       : register-file write port, suppressed while stalled
//   fwd_*      : forwarding tap of the in-flight write, kept alive during stall
module wb_select_stage #(
  parameter int DATA_W = 32,
  parameter int REG_ADDR_W = 5,
  parameter int NSRC = 4,
  parameter int LOAD_IDX = 1,
  parameter int SEL_W = $clog2(NSRC)
) (
  input  logic clk,
  input  logic rst_n,
  wb_select_stage_if.slave up,
  input  logic stall,
  input  logic flush,
  output logic rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic fwd_valid,
  output logic [REG_ADDR_W-1:0] fwd_addr,
  output logic [DATA_W-1:0] fwd_data
);
  logic v_q, v_d, we_q, we_d;
  logic [REG_ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, sel_data, ld_data;
  logic [SEL_W-1:0] sel;
  logic [7:0] byte_v;
  logic [15:0] half_v;
  assign sel = up.wd_sel;
  // out-of-range selects fall through to zero
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NSRC; i++)
      if (int'(sel) == i) sel_data = up.src_data[i*DATA_W +: DATA_W];
  end
  // half loads use only addr_lo[1]; misaligned halves are trapped upstream
  always_comb begin
    byte_v = sel_data[8*up.addr_lo +: 8];
    half_v = sel_data[16*up.addr_lo[1] +: 16];
    ld_data = up.load_size == 2'b00 ? {{(DATA_W-8){up.load_signed & byte_v[7]}}, byte_v}
            : up.load_size == 2'b01 ? {{(DATA_W-16){up.load_signed & half_v[15]}}, half_v}
            : sel_data;
    v_d = flush ? 1'b0 : stall ? v_q : up.in_valid;
    we_d = stall ? we_q : up.reg_write && up.rd_addr != '0;
    waddr_d = stall ? waddr_q : up.rd_addr;
    wdata_d = stall ? wdata_q : int'(sel) == LOAD_IDX ? ld_data : sel_data;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v_q <= 1'b0;
      we_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      v_q <= v_d;
      we_q <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  assign up.in_ready = !stall;
  assign fwd_valid = v_q && we_q;
  assign rf_we = fwd_valid && !stall;
  assign rf_waddr = waddr_q;
  assign fwd_addr = waddr_q;
  assign rf_wdata = wdata_q;
  assign fwd_data = wdata_q;
endmodule

// File: tb/tb_wb_select_stage.sv
// tb_wb_select_stage: randomized self-checking bench for wb_select_stage against a behavioural model
module tb_wb_select_stage;
  localparam int DW = 32, AW = 5, NS = 4, LI = 1, SW = 2;
  logic clk = 1'b0, rst_n = 1'b0, stall = 1'b0, flush = 1'b0;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  wb_select_stage_if #(.DATA_W(DW), .REG_ADDR_W(AW), .NSRC(NS)) up();
  wb_select_stage_if #(.DATA_W(DW), .REG_ADDR_W(AW), .NSRC(3)) up3();
  logic rf_we, fwd_valid, rf_we3, fwd_valid3;
  logic [AW-1:0] rf_waddr, fwd_addr, rf_waddr3, fwd_addr3;
  logic [DW-1:0] rf_wdata, fwd_data, rf_wdata3, fwd_data3;
  wb_select_stage #(.DATA_W(DW), .REG_ADDR_W(AW), .NSRC(NS), .LOAD_IDX(LI)) dut (
    .clk(clk), .rst_n(rst_n), .up(up), .stall(stall), .flush(flush),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data));
  wb_select_stage #(.DATA_W(DW), .REG_ADDR_W(AW), .NSRC(3), .LOAD_IDX(LI)) dut3 (
    .clk(clk), .rst_n(rst_n), .up(up3), .stall(stall), .flush(flush),
    .rf_we(rf_we3), .rf_waddr(rf_waddr3), .rf_wdata(rf_wdata3),
    .fwd_valid(fwd_valid3), .fwd_addr(fwd_addr3), .fwd_data(fwd_data3));

  // expected write data from the source list using byte/halfword arithmetic
  function automatic logic [31:0] model(input int sel, input logic [NS*DW-1:0] src, input int sz, input bit sg, input int lo);
    logic [31:0] raw;
    longint v;
    if (sel >= NS) return 32'h0;
    raw = src[sel*DW +: DW];
    if (sel != LI) return raw;
    if (sz == 0) begin
      v = longint'((raw >> (8*lo)) % 256);
      if (sg && v >= 128) v -= 256;
    end else if (sz == 1) begin
      v = longint'((raw >> (16*(lo/2))) % 65536);
      if (sg && v >= 32768) v -= 65536;
    end else v = longint'(raw);
    return v[31:0];
  endfunction

  function automatic logic [NS*DW-1:0] rnd_src();
    logic [NS*DW-1:0] s;
    for (int i = 0; i < NS; i++) s[i*DW +: DW] = $urandom;
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit val, input int sel, input logic [NS*DW-1:0] src, input int sz, input bit sg, input int lo, input int rd, input bit rw);
    up.in_valid = val;
    up.wd_sel = SW'(sel);
    up.src_data = src;
    up.load_size = 2'(sz);
    up.load_signed = sg;
    up.addr_lo = 2'(lo);
    up.rd_addr = AW'(rd);
    up.reg_write = rw;
  endtask

  task automatic test_reset();
    logic [NS*DW-1:0] s = '0;
    s[31:0] = 32'h12345678;
    drive(1, 0, s, 2, 0, 0, 3, 1);
    tick();
    tick();
    #1;
    checks++;
    if ({rf_we, rf_waddr, rf_wdata, fwd_valid, fwd_addr, fwd_data} !== '0) begin
      failures++;
      $display("FAIL reset_hold got we=%0b a=%0d d=%h fv=%0b want all 0", rf_we, rf_waddr, rf_wdata, fwd_valid);
    end
    rst_n = 1'b1;
    tick();
    up.in_valid = 1'b0;
    #1;
    checks++;
    if ({rf_we, rf_waddr, rf_wdata, fwd_valid, fwd_addr, fwd_data} !== {1'b1, 5'd3, 32'h12345678, 1'b1, 5'd3, 32'h12345678}) begin
      failures++;
      $display("FAIL first_alu got we=%0b a=%0d d=%h want we=1 a=3 d=12345678", rf_we, rf_waddr, rf_wdata);
    end
    stall = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rf_we, rf_waddr, rf_wdata, fwd_valid, fwd_addr, fwd_data} !== '0) begin
      failures++;
      $display("FAIL async_reset got we=%0b a=%0d d=%h fv=%0b want all 0", rf_we, rf_waddr, rf_wdata, fwd_valid);
    end
    stall = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_load_format();
    logic [31:0] exp_tab [5] = '{32'hFFFFFF80, 32'h0000007F, 32'hFFFF80FF, 32'h00007F01, 32'h80FF7F01};
    int sz_tab [5] = '{0, 0, 1, 1, 2};
    bit sg_tab [5] = '{1, 0, 1, 0, 0};
    int lo_tab [5] = '{3, 1, 2, 0, 0};
    logic [NS*DW-1:0] s;
    for (int k = 0; k < 5; k++) begin
      s = rnd_src();
      s[LI*DW +: DW] = 32'h80FF7F01;
      drive(1, LI, s, sz_tab[k], sg_tab[k], lo_tab[k], 10 + k, 1);
      tick();
      up.in_valid = 1'b0;
      #1;
      checks++;
      if ({rf_we, rf_wdata} !== {1'b1, exp_tab[k]}) begin
        failures++;
        $display("FAIL load_fmt case %0d got we=%0b d=%h want we=1 d=%h", k, rf_we, rf_wdata, exp_tab[k]);
      end
    end
  endtask

  task automatic test_source_sweep();
    logic [NS*DW-1:0] s;
    logic [31:0] e;
    int rd, sz, lo;
    bit sg;
    for (int k = 0; k < NS; k++) begin
      s = rnd_src();
      rd = $urandom_range(1, 31);
      sz = $urandom_range(0, 3);
      lo = $urandom_range(0, 3);
      sg = 1'($urandom_range(0, 1));
      e = model(k, s, sz, sg, lo);
      drive(1, k, s, sz, sg, lo, rd, 1);
      tick();
      up.in_valid = 1'b0;
      #1;
      checks++;
      if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, AW'(rd), e}) begin
        failures++;
        $display("FAIL src_sweep sel=%0d got we=%0b a=%0d d=%h want we=1 a=%0d d=%h", k, rf_we, rf_waddr, rf_wdata, rd, e);
      end
    end
  endtask

  task automatic test_nsrc3();
    up3.src_data = {32'hCAFEF00D, 32'h11112222, 32'h33334444};
    up3.load_size = 2'd2;
    up3.load_signed = 1'b0;
    up3.addr_lo = 2'd0;
    up3.reg_write = 1'b1;
    up3.in_valid = 1'b1;
    up3.wd_sel = 2'd3;
    up3.rd_addr = 5'd7;
    tick();
    up3.wd_sel = 2'd2;
    up3.rd_addr = 5'd8;
    #1;
    checks++;
    if ({rf_we3, rf_waddr3, rf_wdata3} !== {1'b1, 5'd7, 32'h0}) begin
      failures++;
      $display("FAIL nsrc3_oob got we=%0b a=%0d d=%h want we=1 a=7 d=00000000", rf_we3, rf_waddr3, rf_wdata3);
    end
    tick();
    up3.in_valid = 1'b0;
    #1;
    checks++;
    if ({rf_we3, rf_waddr3, rf_wdata3} !== {1'b1, 5'd8, 32'hCAFEF00D}) begin
      failures++;
      $display("FAIL nsrc3_top got we=%0b a=%0d d=%h want we=1 a=8 d=cafef00d", rf_we3, rf_waddr3, rf_wdata3);
    end
  endtask

  task automatic test_x0();
    drive(1, 0, rnd_src(), 2, 0, 0, 0, 1);
    tick();
    up.in_valid = 1'b0;
    #1;
    checks++;
    if ({rf_we, fwd_valid} !== 2'b00) begin
      failures++;
      $display("FAIL x0_suppress got we=%0b fv=%0b want 0 0", rf_we, fwd_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] ea [8];
    logic [31:0] ed [8];
    logic [NS*DW-1:0] s;
    int sel, sz, lo;
    bit sg;
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) begin
        s = rnd_src();
        sel = $urandom_range(0, NS - 1);
        sz = $urandom_range(0, 3);
        lo = $urandom_range(0, 3);
        sg = 1'($urandom_range(0, 1));
        ea[i] = AW'($urandom_range(1, 31));
        ed[i] = model(sel, s, sz, sg, lo);
        drive(1, sel, s, sz, sg, lo, int'(ea[i]), 1);
      end else up.in_valid = 1'b0;
      if (i > 0) begin
        #1;
        checks++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, ea[i-1], ed[i-1]}) begin
          failures++;
          $display("FAIL b2b idx %0d got we=%0b a=%0d d=%h want we=1 a=%0d d=%h", i - 1, rf_we, rf_waddr, rf_wdata, ea[i-1], ed[i-1]);
        end
      end
      tick();
    end
    checks++;
    if (rf_we !== 1'b0) begin
      failures++;
      $display("FAIL b2b_end got we=%0b want 0", rf_we);
    end
  endtask

  task automatic test_stall();
    logic [NS*DW-1:0] s = '0;
    s[31:0] = 32'hAAAA0000;
    drive(1, 0, s, 2, 0, 0, 5, 1);
    tick();
    s[31:0] = 32'hBBBB1111;
    drive(1, 0, s, 2, 0, 0, 6, 1);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if ({up.in_ready, fwd_valid, fwd_addr, fwd_data, rf_we} !== {1'b0, 1'b1, 5'd5, 32'hAAAA0000, 1'b0}) begin
        failures++;
        $display("FAIL stall_hold cyc %0d got rdy=%0b fv=%0b fa=%0d fd=%h we=%0b want 0 1 5 aaaa0000 0", k, up.in_ready, fwd_valid, fwd_addr, fwd_data, rf_we);
      end
      tick();
    end
    stall = 1'b0;
    #1;
    checks++;
    if ({up.in_ready, rf_we, rf_waddr, rf_wdata} !== {1'b1, 1'b1, 5'd5, 32'hAAAA0000}) begin
      failures++;
      $display("FAIL stall_release got rdy=%0b we=%0b a=%0d d=%h want 1 1 5 aaaa0000", up.in_ready, rf_we, rf_waddr, rf_wdata);
    end
    tick();
    up.in_valid = 1'b0;
    #1;
    checks++;
    if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd6, 32'hBBBB1111}) begin
      failures++;
      $display("FAIL stall_next got we=%0b a=%0d d=%h want 1 6 bbbb1111", rf_we, rf_waddr, rf_wdata);
    end
    tick();
    checks++;
    if (rf_we !== 1'b0) begin
      failures++;
      $display("FAIL stall_dup got we=%0b want 0", rf_we);
    end
  endtask

  task automatic test_flush();
    drive(1, 0, rnd_src(), 2, 0, 0, 9, 1);
    tick();
    up.in_valid = 1'b0;
    stall = 1'b1;
    #1;
    checks++;
    if ({rf_we, fwd_valid, fwd_addr} !== {1'b0, 1'b1, 5'd9}) begin
      failures++;
      $display("FAIL flush_pre got we=%0b fv=%0b fa=%0d want 0 1 9", rf_we, fwd_valid, fwd_addr);
    end
    tick();
    flush = 1'b1;
    #1;
    checks++;
    if (rf_we !== 1'b0) begin
      failures++;
      $display("FAIL flush_same got we=%0b want 0", rf_we);
    end
    tick();
    stall = 1'b0;
    flush = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++;
      if ({rf_we, fwd_valid} !== 2'b00) begin
        failures++;
        $display("FAIL flush_after cyc %0d got we=%0b fv=%0b want 0 0", k, rf_we, fwd_valid);
      end
      tick();
    end
  endtask

  task automatic test_random();
    bit mv = 1'b0, mwe = 1'b0, rv, rw, sg;
    logic [AW-1:0] ma = '0;
    logic [31:0] md = '0;
    logic [NS*DW-1:0] s;
    int sel, sz, lo, rd;
    for (int c = 0; c < 300; c++) begin
      s = rnd_src();
      rv = 1'($urandom_range(0, 1));
      rw = ($urandom_range(0, 3) != 0);
      sel = $urandom_range(0, NS - 1);
      sz = $urandom_range(0, 3);
      lo = $urandom_range(0, 3);
      sg = 1'($urandom_range(0, 1));
      rd = $urandom_range(0, 31);
      drive(rv, sel, s, sz, sg, lo, rd, rw);
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 9) == 0);
      #1;
      checks++;
      if ({rf_we, fwd_valid, up.in_ready} !== {mv && mwe && !stall, mv && mwe, !stall} ||
          (mv && mwe && {rf_waddr, rf_wdata, fwd_addr, fwd_data} !== {ma, md, ma, md})) begin
        failures++;
        $display("FAIL random cyc %0d got we=%0b fv=%0b a=%0d d=%h want we=%0b fv=%0b a=%0d d=%h", c, rf_we, fwd_valid, rf_waddr, rf_wdata, mv && mwe && !stall, mv && mwe, ma, md);
      end
      if (flush) mv = 1'b0;
      else if (!stall) begin
        mv = rv;
        mwe = rw && rd != 0;
        ma = AW'(rd);
        md = model(sel, s, sz, sg, lo);
      end
      tick();
    end
    stall = 1'b0;
    flush = 1'b0;
    up.in_valid = 1'b0;
  endtask

  initial begin
    drive(0, 0, '0, 2, 0, 0, 0, 0);
    up3.in_valid = 1'b0;
    up3.wd_sel = '0;
    up3.src_data = '0;
    up3.load_size = 2'd2;
    up3.load_signed = 1'b0;
    up3.addr_lo = 2'd0;
    up3.rd_addr = '0;
    up3.reg_write = 1'b0;
    test_reset();
    test_load_format();
    test_source_sweep();
    test_nsrc3();
    test_x0();
    test_back_to_back();
    test_stall();
    test_flush();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
